// File: rtl/arb_out_three_pkg.sv
// Shared definitions for the three-input wormhole output arbiter:
// flit format, FSM state type and round-robin index arithmetic.
package arb_out_three_pkg;

  localparam int DATA_WIDTH = 16;

  // Flit type lives in the two MSBs of every flit
  localparam logic [1:0] TYPE_BODY = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  function automatic logic [1:0] flit_type(input logic [DATA_WIDTH-1:0] f);
    return f[DATA_WIDTH-1 -: 2];
  endfunction

  // (p + k) mod 3 for p, k in 0..2
  function automatic logic [1:0] rr_add(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/arb_out_three_if.sv
// Flit handshake bundle: three upstream requesters (A/B/C) and one downstream port.
interface arb_out_three_if;
  import arb_out_three_pkg::*;

  logic                  A_valid_i;
  logic                  A_ready_o;
  logic [DATA_WIDTH-1:0] A_data_i;
  logic                  B_valid_i;
  logic                  B_ready_o;
  logic [DATA_WIDTH-1:0] B_data_i;
  logic                  C_valid_i;
  logic                  C_ready_o;
  logic [DATA_WIDTH-1:0] C_data_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] data_o;

  modport slave (
    input  A_valid_i, A_data_i, B_valid_i, B_data_i, C_valid_i, C_data_i, ready_i,
    output A_ready_o, B_ready_o, C_ready_o, valid_o, data_o
  );

  modport master (
    output A_valid_i, A_data_i, B_valid_i, B_data_i, C_valid_i, C_data_i, ready_i,
    input  A_ready_o, B_ready_o, C_ready_o, valid_o, data_o
  );

endinterface

// File: rtl/arb_out_three_skid_buf_2.sv
// Two-entry output FIFO with registered occupancy; dout holds the last popped
// flit while empty so the downstream bus does not glitch between packets.
module skid_buf_2
  import arb_out_three_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] last_q;
  logic         wr_q, rd_q;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign full    = (cnt_q == 2'd2);
  assign valid   = (cnt_q != 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;
  assign dout    = valid ? mem_q[rd_q] : last_q;
  assign cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      last_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        last_q <= mem_q[rd_q];
        rd_q   <= ~rd_q;
      end
    end
  end

endmodule

// File: rtl/arb_out_three.sv
// Three-input wormhole output arbiter: round-robin on heads, grant held until
// the tail is accepted, output registered through a 2-entry skid buffer.
module arb_out_three
  import arb_out_three_pkg::*;
#(
  parameter int PRIO_RESET = 0,
  parameter int PCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  arb_out_three_if.slave    bus,
  output logic [PCNT_W-1:0] pkt_cnt_o
);

  arb_state_e            state_q, state_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [PCNT_W-1:0]     pkt_cnt_q;
  logic [2:0]            req, rdy;
  logic [1:0]            win, sel;
  logic                  win_vld, sel_vld;
  logic                  fire, skid_ok, skid_full, skid_valid, pop;
  logic [DATA_WIDTH-1:0] fire_data, skid_dout;

  assign req = {bus.C_valid_i, bus.B_valid_i, bus.A_valid_i};

  // Later iterations overwrite earlier ones, so scanning backwards leaves ptr_q highest priority
  always_comb begin
    win     = ptr_q;
    win_vld = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (req[rr_add(ptr_q, 2'(k))]) begin
        win     = rr_add(ptr_q, 2'(k));
        win_vld = 1'b1;
      end
    end
  end

  assign sel     = (state_q == ARB_LOCK) ? gnt_q : win;
  assign sel_vld = (state_q == ARB_LOCK) ? 1'b1 : win_vld;
  assign skid_ok = ~skid_full;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rdy
      assign rdy[gi] = ~rst & skid_ok & sel_vld & (sel == 2'(gi));
    end
  endgenerate

  assign bus.A_ready_o = rdy[0];
  assign bus.B_ready_o = rdy[1];
  assign bus.C_ready_o = rdy[2];
  assign fire          = |(req & rdy);

  always_comb begin
    case (sel)
      2'd1:    fire_data = bus.B_data_i;
      2'd2:    fire_data = bus.C_data_i;
      default: fire_data = bus.A_data_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (fire) begin
          gnt_d = sel;
          // A stray TAIL in IDLE is forwarded but never opens a grant
          if (flit_type(fire_data) != TYPE_TAIL) state_d = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        if (fire && flit_type(fire_data) == TYPE_TAIL) begin
          state_d = ARB_IDLE;
          ptr_d   = rr_add(gnt_q, 2'd1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= 2'(PRIO_RESET);
      gnt_q     <= 2'd0;
      pkt_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      if (pop && flit_type(skid_dout) == TYPE_TAIL) pkt_cnt_q <= pkt_cnt_q + 1'b1;
    end
  end

  skid_buf_2 #(.W(DATA_WIDTH)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (fire),
    .din   (fire_data),
    .full  (skid_full),
    .pop   (pop),
    .dout  (skid_dout),
    .valid (skid_valid)
  );

  assign bus.valid_o = skid_valid & ~rst;
  assign bus.data_o  = skid_dout;
  assign pop         = bus.valid_o & bus.ready_i;
  assign pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_arb_out_three.sv
// Self-checking bench: queue-based reference model of the arbiter plus directed
// scenarios and a randomized traffic phase.
module tb_arb_out_three;
  import arb_out_three_pkg::*;

  localparam int PCNT_W = 4;
  typedef logic [DATA_WIDTH-1:0] flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb_out_three_if bus();
  logic [PCNT_W-1:0] pkt_cnt;

  arb_out_three #(.PRIO_RESET(0), .PCNT_W(PCNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .pkt_cnt_o (pkt_cnt)
  );

  logic [2:0] drv_v;
  flit_t      drv_d [3];
  logic       ready_r;

  assign bus.A_valid_i = drv_v[0];
  assign bus.B_valid_i = drv_v[1];
  assign bus.C_valid_i = drv_v[2];
  assign bus.A_data_i  = drv_d[0];
  assign bus.B_data_i  = drv_d[1];
  assign bus.C_data_i  = drv_d[2];
  assign bus.ready_i   = ready_r;

  // Reference model state
  flit_t             srcq [3][$];
  flit_t             outq [$];
  int                head_log [$];
  int                owner = -1;
  int                rr    = 0;
  logic [PCNT_W-1:0] mcnt  = '0;
  int                tails = 0;
  bit                en [3];
  bit                force_valid = 1'b1;
  int                rdy_mode    = 0;
  int                seq         = 0;
  int                n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic flit_t mk(input logic [1:0] t, input int s, input int q);
    logic [1:0]  s2;
    logic [11:0] q2;
    s2 = s[1:0];
    q2 = q[11:0];
    return {t, s2, q2};
  endfunction

  task automatic add_pkt(input int s, input int len);
    for (int i = 0; i < len; i++) begin
      logic [1:0] t;
      t = (i == 0) ? TYPE_HEAD : (i == len - 1) ? TYPE_TAIL : TYPE_BODY;
      srcq[s].push_back(mk(t, s, seq));
      seq++;
    end
  endtask

  function automatic logic [2:0] dut_rdy();
    return {bus.C_ready_o, bus.B_ready_o, bus.A_ready_o};
  endfunction

  // Which input may be accepted this cycle, from the arbitration rules
  function automatic logic [2:0] model_rdy();
    logic [2:0] r;
    r = 3'b000;
    if (outq.size() >= 2) return r;
    if (owner >= 0) begin
      r[owner] = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (drv_v[(rr + k) % 3]) begin
          r[(rr + k) % 3] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic bit busy();
    return (srcq[0].size() + srcq[1].size() + srcq[2].size() + outq.size()) != 0;
  endfunction

  task automatic cycle();
    logic [2:0] exp_r;
    int         fire_s;
    bit         pop;
    flit_t      f;
    for (int s = 0; s < 3; s++) begin
      drv_v[s] = en[s] && srcq[s].size() > 0 && (force_valid || $urandom_range(0, 3) != 0);
      drv_d[s] = (srcq[s].size() > 0) ? srcq[s][0] : flit_t'($urandom);
    end
    ready_r = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    @(negedge clk);
    exp_r = model_rdy();
    chk("ready_vec", int'(dut_rdy()), int'(exp_r));
    chk("valid_o", int'(bus.valid_o), int'(outq.size() > 0));
    if (outq.size() > 0) chk("data_o", int'(bus.data_o), int'(outq[0]));
    chk("pkt_cnt", int'(pkt_cnt), int'(mcnt));
    pop    = (outq.size() > 0) && ready_r;
    fire_s = -1;
    for (int s = 0; s < 3; s++) if (drv_v[s] && exp_r[s]) fire_s = s;
    if (pop) begin
      f = outq.pop_front();
      if (flit_type(f) == TYPE_TAIL) begin
        mcnt++;
        tails++;
      end
      if (flit_type(f) == TYPE_HEAD) head_log.push_back(int'(f[DATA_WIDTH-3 -: 2]));
    end
    if (fire_s >= 0) begin
      f = srcq[fire_s].pop_front();
      outq.push_back(f);
      if (owner < 0) begin
        if (flit_type(f) != TYPE_TAIL) owner = fire_s;
      end else if (flit_type(f) == TYPE_TAIL) begin
        rr    = (owner + 1) % 3;
        owner = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm, input int budget);
    int c;
    c = 0;
    while (busy() && c < budget) begin
      cycle();
      c++;
    end
    if (busy()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout after %0d cycles, flits still pending (required none)", nm, budget);
      for (int s = 0; s < 3; s++) srcq[s].delete();
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    drv_v = 3'b000;
    @(negedge clk);
    chk("rst_ready", int'(dut_rdy()), 0);
    chk("rst_valid", int'(bus.valid_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) srcq[s].delete();
    outq.delete();
    head_log.delete();
    owner = -1;
    rr    = 0;
    mcnt  = '0;
    tails = 0;
  endtask

  initial begin
    drv_v   = 3'b000;
    ready_r = 1'b0;
    for (int s = 0; s < 3; s++) drv_d[s] = '0;
    @(posedge clk);
    #1;
    do_reset();

    // 1: single 3-flit packet from A
    en = '{1'b1, 1'b0, 1'b0};
    force_valid = 1'b1;
    rdy_mode    = 0;
    add_pkt(0, 3);
    drain("t1_drain", 50);
    chk("t1_pkt_cnt", int'(pkt_cnt), 1);
    $display("t1 single packet: pkt_cnt=%0d", pkt_cnt);

    // 2: simultaneous heads from A, B, C, then A and B together to show ptr back at A
    do_reset();
    en = '{1'b1, 1'b1, 1'b1};
    add_pkt(0, 3); add_pkt(1, 3); add_pkt(2, 3);
    drain("t2_drain", 100);
    add_pkt(1, 2); add_pkt(0, 2);
    drain("t2b_drain", 50);
    chk("t2_nheads", head_log.size(), 5);
    if (head_log.size() == 5) begin
      chk("t2_head0", head_log[0], 0);
      chk("t2_head1", head_log[1], 1);
      chk("t2_head2", head_log[2], 2);
      chk("t2_head3", head_log[3], 0);
    end
    $display("t2 rr order: %0d heads, pkt_cnt=%0d", head_log.size(), pkt_cnt);

    // 3: downstream stall fills the skid buffer
    do_reset();
    en = '{1'b1, 1'b0, 1'b0};
    add_pkt(0, 4);
    rdy_mode = 0;
    cycle();
    rdy_mode = 1;
    repeat (5) cycle();
    chk("t3_a_blocked", int'(bus.A_ready_o), 0);
    chk("t3_valid_held", int'(bus.valid_o), 1);
    rdy_mode = 0;
    drain("t3_drain", 50);
    chk("t3_pkt_cnt", int'(pkt_cnt), 1);
    $display("t3 stall: pkt_cnt=%0d", pkt_cnt);

    // 4: B waits behind A's locked packet
    do_reset();
    en = '{1'b1, 1'b1, 1'b0};
    add_pkt(0, 4); add_pkt(1, 3);
    cycle();
    drain("t4_drain", 50);
    chk("t4_nheads", head_log.size(), 2);
    if (head_log.size() == 2) chk("t4_second_b", head_log[1], 1);
    $display("t4 lock: heads=%0d", head_log.size());

    // 5: reset in the middle of C's packet after B moved ptr to C
    do_reset();
    en = '{1'b1, 1'b1, 1'b1};
    add_pkt(1, 2);
    drain("t5a_drain", 50);
    add_pkt(2, 3);
    for (int i = 0; i < 20 && srcq[2].size() > 1; i++) cycle();
    do_reset();
    @(negedge clk);
    chk("t5_pkt_cnt_rst", int'(pkt_cnt), 0);
    chk("t5_valid_rst", int'(bus.valid_o), 0);
    @(posedge clk);
    #1;
    add_pkt(2, 3); add_pkt(1, 3); add_pkt(0, 3);
    drain("t5_drain", 100);
    if (head_log.size() > 0) chk("t5_first_a", head_log[0], 0);
    chk("t5_pkt_cnt", int'(pkt_cnt), 3);
    $display("t5 mid-packet reset: pkt_cnt=%0d", pkt_cnt);

    // 6: counter wrap after 2^PCNT_W packets
    do_reset();
    en = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 15; i++) add_pkt(0, 2);
    drain("t6a_drain", 200);
    chk("t6_cnt_15", int'(pkt_cnt), 15);
    add_pkt(0, 2);
    drain("t6b_drain", 50);
    chk("t6_cnt_wrap", int'(pkt_cnt), 0);
    $display("t6 wrap: pkt_cnt=%0d", pkt_cnt);

    // 7: randomized traffic
    do_reset();
    en = '{1'b1, 1'b1, 1'b1};
    force_valid = 1'b0;
    rdy_mode    = 2;
    for (int i = 0; i < 150; i++) add_pkt($urandom_range(0, 2), $urandom_range(2, 5));
    drain("t7_drain", 20000);
    chk("t7_tails", tails, 150);
    chk("t7_pkt_cnt", int'(pkt_cnt), 150 % 16);
    $display("t7 random: tails=%0d pkt_cnt=%0d", tails, pkt_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (required finish)");
    $fatal(1);
  end

endmodule
